router_net_iface: RTL and testbench

- Network interface that sits on the router's local port (Eject/Inject, port index NUM_PORTS-1), between the tile host and the router input stage.
- Injection side:
  - Queues host packets.
  - Forms single-flit packets with the destination router ID in the flit MSBs.
  - Injects them into the router local input under credit flow control.
- Ejection side:
  - Buffers flits leaving the router local output.
  - Presents them to the host via valid/ready.
  - Checks the destination ID.

---
 rtl/router_net_iface.sv | 148 ++++++++++++++
 tb/tb_router_net_iface.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_net_iface.sv
// router_net_iface
//   Network interface on the router's local (eject/inject) port.
//   Injection: host packets are queued, formed into single-flit packets
//   {dest, payload}, and sent to the router local input under credit flow
//   control (one credit per free local-input VC).
//   Ejection: flits from the router local output are buffered and handed to
//   the host with valid/ready; the destination field is checked on arrival.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   host_inj_*            host -> NI packet interface (valid/ready)
//   rtr_in_data/valid     NI -> router local input (registered)
//   rtr_credit_in         router returns one local-input VC credit (pulse)
//   rtr_out_data/valid    router local output -> NI
//   host_ej_*             NI -> host ejected flit interface (valid/ready)
//   credit_count          current injection credits
//   err_credit_ovf        sticky: credit returned while already at NUM_VC
//   err_ej_drop           sticky: flit lost because ejection FIFO was full
//   err_misroute          sticky: ejected flit not addressed to ROUTER_ID

`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module router_net_iface #(
  parameter int NUM_VC         = 4,
  parameter int NUM_ROUTERS    = 16,
  parameter int ROUTER_ID      = 0,
  parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
  parameter int PAYLOAD_BITS   = `FLIT_DATA_WIDTH - ROUTER_ID_BITS,
  parameter int INJ_DEPTH      = 4,
  parameter int EJ_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_inj_valid,
  output logic                          host_inj_ready,
  input  logic [ROUTER_ID_BITS-1:0]     host_inj_dest,
  input  logic [PAYLOAD_BITS-1:0]       host_inj_payload,
  output logic [`FLIT_DATA_WIDTH-1:0]   rtr_in_data,
  output logic                          rtr_in_valid,
  input  logic                          rtr_credit_in,
  input  logic [`FLIT_DATA_WIDTH-1:0]   rtr_out_data,
  input  logic                          rtr_out_valid,
  output logic                          host_ej_valid,
  input  logic                          host_ej_ready,
  output logic [ROUTER_ID_BITS-1:0]     host_ej_src_dest,
  output logic [PAYLOAD_BITS-1:0]       host_ej_payload,
  output logic [$clog2(NUM_VC+1)-1:0]   credit_count,
  output logic                          err_credit_ovf,
  output logic                          err_ej_drop,
  output logic                          err_misroute
);

  localparam int FW  = `FLIT_DATA_WIDTH;
  localparam int CW  = $clog2(NUM_VC + 1);
  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int EAW = $clog2(EJ_DEPTH);

  // ---------------- injection path ----------------
  logic [FW-1:0] inj_mem [INJ_DEPTH];
  logic [IAW:0]  inj_wr, inj_rd;   // extra MSB distinguishes full from empty
  logic          inj_empty, inj_full, inj_push, send;

  assign inj_empty      = (inj_wr == inj_rd);
  assign inj_full       = (inj_wr[IAW] != inj_rd[IAW]) &&
                          (inj_wr[IAW-1:0] == inj_rd[IAW-1:0]);
  assign host_inj_ready = !inj_full;
  assign inj_push       = host_inj_valid && !inj_full;
  assign send           = !inj_empty && (credit_count != '0);

  always_ff @(posedge clk) begin
    if (inj_push)
      inj_mem[inj_wr[IAW-1:0]] <= {host_inj_dest, host_inj_payload};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inj_wr         <= '0;
      inj_rd         <= '0;
      rtr_in_valid   <= 1'b0;
      rtr_in_data    <= '0;
      credit_count   <= CW'(NUM_VC);
      err_credit_ovf <= 1'b0;
    end else begin
      if (inj_push)
        inj_wr <= inj_wr + 1'b1;
      rtr_in_valid <= send;
      if (send) begin
        inj_rd      <= inj_rd + 1'b1;
        rtr_in_data <= inj_mem[inj_rd[IAW-1:0]];
      end
      // A send and a returned credit in the same cycle cancel out.
      if (send && !rtr_credit_in)
        credit_count <= credit_count - CW'(1);
      else if (!send && rtr_credit_in) begin
        if (credit_count == CW'(NUM_VC))
          err_credit_ovf <= 1'b1;
        else
          credit_count <= credit_count + CW'(1);
      end
    end
  end

  // ---------------- ejection path ----------------
  logic [FW-1:0] ej_mem [EJ_DEPTH];
  logic [EAW:0]  ej_wr, ej_rd;
  logic          ej_empty, ej_full, ej_pop, ej_push;
  logic [FW-1:0] ej_head;

  assign ej_empty = (ej_wr == ej_rd);
  assign ej_full  = (ej_wr[EAW] != ej_rd[EAW]) &&
                    (ej_wr[EAW-1:0] == ej_rd[EAW-1:0]);
  assign host_ej_valid = !ej_empty;
  assign ej_pop   = !ej_empty && host_ej_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign ej_push  = rtr_out_valid && (!ej_full || ej_pop);

  assign ej_head          = ej_mem[ej_rd[EAW-1:0]];
  assign host_ej_src_dest = ej_head[FW-1 -: ROUTER_ID_BITS];
  assign host_ej_payload  = ej_head[PAYLOAD_BITS-1:0];

  always_ff @(posedge clk) begin
    if (ej_push)
      ej_mem[ej_wr[EAW-1:0]] <= rtr_out_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ej_wr        <= '0;
      ej_rd        <= '0;
      err_ej_drop  <= 1'b0;
      err_misroute <= 1'b0;
    end else begin
      if (ej_push)
        ej_wr <= ej_wr + 1'b1;
      if (ej_pop)
        ej_rd <= ej_rd + 1'b1;
      if (rtr_out_valid && !ej_push)
        err_ej_drop <= 1'b1;
      // Misrouted flits are still delivered; only the flag records them.
      if (ej_push &&
          (rtr_out_data[FW-1 -: ROUTER_ID_BITS] != ROUTER_ID_BITS'(ROUTER_ID)))
        err_misroute <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_net_iface.sv
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 32
`endif

module tb_router_net_iface;

  localparam int FW   = `FLIT_DATA_WIDTH;
  localparam int RIB  = 4;
  localparam int PB   = FW - RIB;
  localparam int NVC  = 4;
  localparam int RID  = 0;
  localparam int IDEP = 4;
  localparam int EDEP = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           host_inj_valid;
  logic           host_inj_ready;
  logic [RIB-1:0] host_inj_dest;
  logic [PB-1:0]  host_inj_payload;
  logic [FW-1:0]  rtr_in_data;
  logic           rtr_in_valid;
  logic           rtr_credit_in;
  logic [FW-1:0]  rtr_out_data;
  logic           rtr_out_valid;
  logic           host_ej_valid;
  logic           host_ej_ready;
  logic [RIB-1:0] host_ej_src_dest;
  logic [PB-1:0]  host_ej_payload;
  logic [2:0]     credit_count;
  logic           err_credit_ovf, err_ej_drop, err_misroute;

  router_net_iface #(
    .NUM_VC(NVC), .NUM_ROUTERS(16), .ROUTER_ID(RID),
    .INJ_DEPTH(IDEP), .EJ_DEPTH(EDEP)
  ) dut (
    .clk(clk), .reset(reset),
    .host_inj_valid(host_inj_valid), .host_inj_ready(host_inj_ready),
    .host_inj_dest(host_inj_dest), .host_inj_payload(host_inj_payload),
    .rtr_in_data(rtr_in_data), .rtr_in_valid(rtr_in_valid),
    .rtr_credit_in(rtr_credit_in),
    .rtr_out_data(rtr_out_data), .rtr_out_valid(rtr_out_valid),
    .host_ej_valid(host_ej_valid), .host_ej_ready(host_ej_ready),
    .host_ej_src_dest(host_ej_src_dest), .host_ej_payload(host_ej_payload),
    .credit_count(credit_count),
    .err_credit_ovf(err_credit_ovf), .err_ej_drop(err_ej_drop),
    .err_misroute(err_misroute)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [FW-1:0] data;
    int            at;
  } exp_t;

  exp_t          exp_inj[$];   // flits expected on rtr_in, with cycle
  logic [FW-1:0] exp_ej[$];    // flits expected at the host, in order

  // Reference model state (what the NI should hold after the last edge)
  logic [FW-1:0] m_inj[$];
  int            m_cred;
  int            m_ej;
  bit            m_ovf, m_drop, m_mis;
  bit            model_ok = 0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Scoreboard monitor: pops expectations whenever the DUT presents output.
  always @(negedge clk) begin
    if (rtr_in_valid === 1'b1) begin
      if (exp_inj.size() == 0)
        chk("inj_unexpected_flit", 1, 0);
      else begin
        exp_t e;
        e = exp_inj.pop_front();
        chk("inj_flit_data", rtr_in_data, e.data);
        chk("inj_flit_cycle", cyc, e.at);
      end
    end
    if (!reset && host_ej_valid === 1'b1 && host_ej_ready) begin
      if (exp_ej.size() == 0)
        chk("ej_unexpected_flit", 1, 0);
      else
        chk("ej_flit", {host_ej_src_dest, host_ej_payload}, exp_ej.pop_front());
    end
  end

  // Checks visible state against the model, then advances the model for the
  // upcoming edge using the inputs currently driven, then waits that edge.
  task automatic tick();
    bit send, push, ej_pop, ej_acc;
    if (model_ok) begin
      chk("host_inj_ready", host_inj_ready, m_inj.size() < IDEP);
      chk("credit_count", credit_count, m_cred);
      chk("host_ej_valid", host_ej_valid, m_ej > 0);
      chk("err_credit_ovf", err_credit_ovf, m_ovf);
      chk("err_ej_drop", err_ej_drop, m_drop);
      chk("err_misroute", err_misroute, m_mis);
      if (rtr_in_valid === 1'b0 && m_inj.size() == 0 && exp_inj.size() == 0)
        chk("inj_idle", rtr_in_valid, 0);
    end
    if (reset) begin
      m_inj.delete();
      exp_ej.delete();
      m_cred = NVC; m_ej = 0;
      m_ovf = 0; m_drop = 0; m_mis = 0;
      model_ok = 1;
    end else begin
      send = (m_inj.size() > 0) && (m_cred > 0);
      push = host_inj_valid && (m_inj.size() < IDEP);
      if (send) begin
        exp_t e;
        e.data = m_inj.pop_front();
        e.at   = cyc + 1;
        exp_inj.push_back(e);
      end
      if (push) m_inj.push_back({host_inj_dest, host_inj_payload});
      if (send && !rtr_credit_in) m_cred--;
      else if (!send && rtr_credit_in) begin
        if (m_cred == NVC) m_ovf = 1;
        else m_cred++;
      end
      ej_pop = (m_ej > 0) && host_ej_ready;
      ej_acc = rtr_out_valid && ((m_ej < EDEP) || ej_pop);
      if (rtr_out_valid && !ej_acc) m_drop = 1;
      if (ej_acc) begin
        exp_ej.push_back(rtr_out_data);
        if (rtr_out_data[FW-1 -: RIB] != RIB'(RID)) m_mis = 1;
      end
      m_ej = m_ej + int'(ej_acc) - int'(ej_pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    host_inj_valid = 0; rtr_credit_in = 0; rtr_out_valid = 0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  initial begin
    reset = 1;
    host_inj_valid = 0; host_inj_dest = '0; host_inj_payload = '0;
    rtr_credit_in = 0; rtr_out_valid = 0; rtr_out_data = '0;
    host_ej_ready = 0;
    tick(); tick();
    reset = 0;

    // single packet: dest 5, payload 0x123
    host_inj_valid = 1; host_inj_dest = 4'd5; host_inj_payload = PB'(28'h123);
    tick();
    idle(4);
    rtr_credit_in = 1; tick(); rtr_credit_in = 0;

    // credit exhaustion: keep offering until the FIFO is full
    for (int i = 0; i < 10; i++) begin
      host_inj_valid = 1; host_inj_dest = RIB'($urandom);
      host_inj_payload = PB'($urandom);
      tick();
    end
    idle(3);
    rtr_credit_in = 1; tick();
    idle(3);
    for (int i = 0; i < 12; i++) begin
      rtr_credit_in = 1; tick(); rtr_credit_in = 0; tick();
    end
    do_reset();

    // send and credit together at count 2, then credit overflow at NUM_VC
    for (int i = 0; i < 2; i++) begin
      host_inj_valid = 1; host_inj_dest = RIB'($urandom);
      host_inj_payload = PB'($urandom); tick();
    end
    idle(2);
    host_inj_valid = 1; host_inj_payload = PB'($urandom); tick();
    host_inj_valid = 0; rtr_credit_in = 1; tick();
    idle(1);
    rtr_credit_in = 1; tick(); tick(); tick();
    idle(2);

    // ejection backpressure: 5 flits into a 4-entry FIFO
    do_reset();
    host_ej_ready = 0;
    for (int i = 0; i < 5; i++) begin
      rtr_out_valid = 1; rtr_out_data = {RIB'(RID), PB'($urandom)}; tick();
    end
    idle(1);
    host_ej_ready = 1;
    idle(6);

    // full FIFO with pop and push together: no drop
    do_reset();
    host_ej_ready = 0;
    for (int i = 0; i < 4; i++) begin
      rtr_out_valid = 1; rtr_out_data = {RIB'(RID), PB'($urandom)}; tick();
    end
    host_ej_ready = 1;
    rtr_out_valid = 1; rtr_out_data = {RIB'(RID), PB'($urandom)}; tick();
    idle(6);

    // misrouted flit is flagged and still delivered
    rtr_out_valid = 1; rtr_out_data = {RIB'(RID + 1), PB'($urandom)}; tick();
    idle(3);

    // random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      reset            = (i == 200);
      host_inj_valid   = ($urandom_range(0, 2) != 0);
      host_inj_dest    = RIB'($urandom);
      host_inj_payload = PB'($urandom);
      rtr_credit_in    = ($urandom_range(0, 2) == 0);
      rtr_out_valid    = ($urandom_range(0, 1) == 0);
      rtr_out_data     = ($urandom_range(0, 7) == 0) ? FW'($urandom)
                                                     : {RIB'(RID), PB'($urandom)};
      host_ej_ready    = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset = 0;

    // drain both paths
    host_inj_valid = 0; rtr_out_valid = 0; host_ej_ready = 1;
    for (int i = 0; i < 40; i++) begin
      rtr_credit_in = ($urandom_range(0, 1) == 0);
      tick();
    end
    rtr_credit_in = 0;
    tick();
    @(negedge clk); #1;
    chk("drain_inj_model", m_inj.size(), 0);
    chk("drain_inj_scoreboard", exp_inj.size(), 0);
    chk("drain_ej_scoreboard", exp_ej.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
